// File: rtl/core_pkg.sv
// Shared decode-side definitions: RV32 base opcodes, fetch-queue entry layout and
// the opcode legality helper used by the fetch queue's illegal-instruction tag.
// Combinational only; no handshake.
package core_pkg;

  localparam int IFQ_XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Entry layout at the default 32-bit width. The queue packs its storage words
  // in this same field order (instr in the MSBs, illegal in the LSB).
  typedef struct packed {
    logic [IFQ_XLEN-1:0] instr;
    logic [IFQ_XLEN-1:0] pc;
    logic                illegal;
  } ifq_entry_t;

  // Flags compressed (non-32-bit) encodings and any major opcode outside the
  // supported base set.
  function automatic logic is_illegal_instr(input logic [6:0] opc);
    logic known;
    known = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
      default: known = 1'b0;
    endcase
    return (opc[1:0] != 2'b11) || !known;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry storage for the fetch queue: DEPTH x WIDTH register array, one write port,
// one asynchronous read port. Write lands on the rising edge; read is same-cycle.
// No handshake; the caller owns pointers and occupancy. Contents are not reset.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (combinational read).
module ifq_storage
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue between fetch and decode: buffers {instr, pc} entries.
// Latency: a word pushed into an empty queue is visible one cycle later (no bypass).
// Backpressure: in_ready_o drops at DEPTH entries and recovers the cycle after a pop;
// both status outputs come from the registered count only.
// Ports: clk_i, rst_ni (async, active-low), flush_i (drops all entries and any
// same-cycle push/pop), in_* (fetch side), out_* (decode head), count_o (occupancy).
// Optional build macro IFQ_ILLEGAL_CHECK_EN: store a per-entry illegal tag and drive
// out_illegal_o from it; otherwise out_illegal_o is tied low and no tag is stored.
module instr_fetch_queue
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_WIDTH-1:0]    in_instr_i,
  input  logic [DATA_WIDTH-1:0]    in_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_instr_o,
  output logic [6:0]               out_opcode_o,
  output logic [DATA_WIDTH-1:0]    out_pc_o,
  output logic                     out_illegal_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef IFQ_ILLEGAL_CHECK_EN
  localparam int ENTRY_W = 2*DATA_WIDTH + 1;
`else
  localparam int ENTRY_W = 2*DATA_WIDTH;
`endif

  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Status from registered count only: no in_valid->out_valid or
  // out_ready->in_ready combinational path.
  assign in_ready_o  = (count != CW'(DEPTH));
  assign out_valid_o = (count != '0);
  assign count_o     = count;

  // A flush cancels any handshake that happens to complete in the same cycle.
  assign push = in_valid_i  && in_ready_o  && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

`ifdef IFQ_ILLEGAL_CHECK_EN
  assign wr_entry = {in_instr_i, in_pc_i, is_illegal_instr(in_instr_i[6:0])};
  assign out_illegal_o = rd_entry[0];
`else
  assign wr_entry = {in_instr_i, in_pc_i};
  assign out_illegal_o = 1'b0;
`endif

  // Field order matches ifq_entry_t: instr in the MSBs, then pc, then the tag.
  assign out_instr_o  = rd_entry[ENTRY_W-1 -: DATA_WIDTH];
  assign out_pc_o     = rd_entry[ENTRY_W-DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_opcode_o = out_instr_o[6:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk     (clk_i),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

endmodule
